neighbor_max_agg: RTL and testbench
===================================

NEIGHBOR_MAX_AGG -- requirements
Module: neighbor_max_agg

Interface
REQ-001 Parameter LANES, default 16: signed feature lanes per word.
REQ-002 Parameter DATA_WIDTH, default 8: bits per lane, two's complement.
REQ-003 Parameter K_MAX, default 32: maximum neighbours per centroid; KW = clog2(K_MAX+1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a group; sampled in IDLE only.
REQ-007 num_nb  input  KW  neighbour count K for the group; sampled with start.
REQ-008 sub_en  input  1  mode: 1 = max minus centroid, 0 = plain max; sampled with start.
REQ-009 c_valid / c_ready  input / output  1 / 1  centroid handshake.
REQ-010 c_data  input  LANES*DATA_WIDTH  centroid feature word.
REQ-011 nb_valid / nb_ready  input / output  1 / 1  neighbour handshake.
REQ-012 nb_data  input  LANES*DATA_WIDTH  neighbour feature word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_data  output  LANES*DATA_WIDTH  aggregated word.
REQ-015 out_err  output  1  qualifies out_data; 1 = group had K=0.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, LOAD_C, ACCUM, SUB, OUT.
REQ-018 IDLE + start: latch K = min(num_nb, K_MAX) and sub_en; go LOAD_C if sub_en=1, else ACCUM; if K=0 go OUT directly with out_err=1, out_data=0.
REQ-019 LOAD_C: c_ready=1; on c_valid&c_ready register centroid, go ACCUM (or OUT with err if K=0).
REQ-020 ACCUM: nb_ready=1; each accepted beat updates per-lane running max (signed compare); first beat loads directly, not compared against reset value.
REQ-021 Neighbour counter increments per accepted beat; on the K-th accepted beat go SUB if sub_en=1, else OUT.
REQ-022 SUB (one cycle): per lane result = max - centroid computed in DATA_WIDTH+1 bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; go OUT.
REQ-023 OUT: out_valid=1; out_data/out_err stable while out_valid & !out_ready; on out_valid&out_ready go IDLE.
REQ-024 Latency from K-th neighbour handshake edge to out_valid high: 1 cycle (sub_en=0), 2 cycles (sub_en=1).
REQ-025 c_ready, nb_ready, out_valid are registered-state decodes, never high outside their state; no combinational path from out_ready to nb_ready.
REQ-026 start while busy=1 is ignored; num_nb/sub_en changes mid-group have no effect.
REQ-027 nb_valid in LOAD_C is not accepted (nb_ready=0); neighbours always follow the centroid.
REQ-028 Back-to-back: start may be asserted the cycle after out handshake; IDLE lasts at least one cycle.
REQ-029 Idle nb_valid/c_valid with ready low are stalls, not errors; beats may have arbitrary bubbles.

Reset
REQ-030 rstn low asynchronously forces IDLE, clears counter, max registers, centroid register, out_data=0, out_err=0, out_valid=0, c_ready=0, nb_ready=0, busy=0.
REQ-031 Reset mid-group discards the partial result; no output is produced for that group after release.
REQ-032 First start accepted on the first rising edge with rstn high.

Verification
REQ-033 LANES=16, DW=8, sub_en=0, K=3, lane0 inputs 5,-7,12 -> lane0 out 12; out_valid 1 cycle after 3rd beat; out_err=0.
REQ-034 sub_en=1, centroid lane0 = -100, neighbours lane0 = 100,90 -> raw 200 saturates to 127; lane1 centroid 10, neighbours -128,-128 -> -128-10 saturates to -128.
REQ-035 K=0 with start -> out_valid with out_err=1, out_data=0, no c_ready/nb_ready pulse; num_nb=40 with K_MAX=32 -> exactly 32 beats accepted.
REQ-036 out_ready held low 5 cycles in OUT -> out_data unchanged, nb_ready=0, start ignored; release -> IDLE next cycle.
REQ-037 Random nb_valid bubbles (50%), K=32, all-negative lanes -> result equals software max of accepted beats only.
REQ-038 rstn pulsed low after 2 of 4 beats -> all outputs at reset values immediately; new group after release yields correct result unaffected by old beats.

Source files
------------

// File: rtl/neighbor_max_agg.sv
// neighbor_max_agg: per-lane signed maximum over K neighbour feature words,
// optionally followed by a saturating subtraction of a centroid word.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. Valid, once raised by a producer, may be dropped again only after the
// transfer (this block's out_valid obeys that). Every ready/valid this block
// drives is a pure decode of the registered state. No ready depends
// combinationally on any input.
module neighbor_max_agg #(
    parameter  int LANES      = 16,
    parameter  int DATA_WIDTH = 8,
    parameter  int K_MAX      = 32,
    localparam int KW         = $clog2(K_MAX + 1),
    localparam int WW         = LANES * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [KW-1:0] num_nb,
    input  logic          sub_en,
    input  logic          c_valid,
    output logic          c_ready,
    input  logic [WW-1:0] c_data,
    input  logic          nb_valid,
    output logic          nb_ready,
    input  logic [WW-1:0] nb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_data,
    output logic          out_err,
    output logic          busy,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_C = 3'd1,
        ACCUM  = 3'd2,
        SUB    = 3'd3,
        OUT    = 3'd4
    } state_e;

    localparam logic [KW-1:0] K_MAX_W = KW'(K_MAX);
    localparam int            DW      = DATA_WIDTH;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic            sub_q, sub_d;
    logic [WW-1:0]   max_q, max_d;
    logic [WW-1:0]   cen_q, cen_d;
    logic [WW-1:0]   out_q, out_d;
    logic            err_q, err_d;
    logic [DW:0]     diff;

    // Handshake strobes and status are decodes of the registered state only.
    assign c_ready     = (state_q == LOAD_C);
    assign nb_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == OUT);
    assign busy        = (state_q != IDLE);
    assign out_data    = out_q;
    assign out_err     = err_q;
    assign dbg_state_o = state_q;

    // Next-state and datapath update for the group sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        max_d   = max_q;
        cen_d   = cen_q;
        out_d   = out_q;
        err_d   = err_q;
        diff    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d   = (num_nb > K_MAX_W) ? K_MAX_W : num_nb;
                    sub_d = sub_en;
                    cnt_d = '0;
                    if (num_nb == '0) begin
                        // Empty group: flag it and report a zero word.
                        out_d   = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end else begin
                        state_d = sub_en ? LOAD_C : ACCUM;
                    end
                end
            end
            LOAD_C: begin
                if (c_valid) begin
                    cen_d = c_data;
                    if (k_q == '0) begin
                        out_d   = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (nb_valid) begin
                    // First beat loads unconditionally; later beats keep the signed max.
                    for (int i = 0; i < LANES; i++) begin
                        if ((cnt_q == '0) ||
                            ($signed(nb_data[i*DW +: DW]) > $signed(max_q[i*DW +: DW]))) begin
                            max_d[i*DW +: DW] = nb_data[i*DW +: DW];
                        end
                    end
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_d == k_q) begin
                        if (sub_q) begin
                            state_d = SUB;
                        end else begin
                            out_d   = max_d;
                            err_d   = 1'b0;
                            state_d = OUT;
                        end
                    end
                end
            end
            SUB: begin
                // Difference in DW+1 bits; a sign/next-bit disagreement means it left the DW range.
                for (int i = 0; i < LANES; i++) begin
                    diff = {max_q[i*DW+DW-1], max_q[i*DW +: DW]} -
                           {cen_q[i*DW+DW-1], cen_q[i*DW +: DW]};
                    if (diff[DW] != diff[DW-1]) begin
                        out_d[i*DW +: DW] = diff[DW] ? {1'b1, {(DW-1){1'b0}}}
                                                     : {1'b0, {(DW-1){1'b1}}};
                    end else begin
                        out_d[i*DW +: DW] = diff[DW-1:0];
                    end
                end
                err_d   = 1'b0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial group.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            max_q   <= '0;
            cen_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            max_q   <= max_d;
            cen_q   <= cen_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_neighbor_max_agg.sv
// Testbench for neighbor_max_agg: directed and randomized groups checked
// against a plain-arithmetic reference of the per-lane max / saturating subtract.
module tb_neighbor_max_agg;

    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int K_MAX = 32;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int WW    = LANES * DW;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [KW-1:0] num_nb;
    logic          sub_en;
    logic          c_valid;
    logic          c_ready;
    logic [WW-1:0] c_data;
    logic          nb_valid;
    logic          nb_ready;
    logic [WW-1:0] nb_data;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;
    logic          out_err;
    logic          busy;
    logic [2:0]    dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] beats[$];
    logic [WW-1:0] cen_word;
    logic [WW-1:0] last_out;
    logic [WW-1:0] w;

    neighbor_max_agg #(
        .LANES      (LANES),
        .DATA_WIDTH (DW),
        .K_MAX      (K_MAX)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .num_nb      (num_nb),
        .sub_en      (sub_en),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_data      (c_data),
        .nb_valid    (nb_valid),
        .nb_ready    (nb_ready),
        .nb_data     (nb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] rand_word(input bit neg);
        logic [WW-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[l*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
            if (neg) r[l*DW + DW - 1] = 1'b1;
        end
        return r;
    endfunction

    task automatic prepare(input int n, input bit neg);
        beats.delete();
        for (int j = 0; j < n; j++) beats.push_back(rand_word(neg));
    endtask

    // Reference: max of the first k beats per lane, then optional clamp(max - centroid).
    function automatic logic [WW-1:0] ref_result(input int k, input bit sub);
        logic [WW-1:0] r;
        logic [WW-1:0] bw;
        logic [DW-1:0] lane_v;
        int m;
        int v;
        int d;
        int lo;
        int hi;
        r  = '0;
        lo = -(1 << (DW - 1));
        hi = (1 << (DW - 1)) - 1;
        if (k == 0) return r;
        for (int l = 0; l < LANES; l++) begin
            m = lo - 1;
            for (int j = 0; j < k; j++) begin
                bw     = beats[j];
                lane_v = bw[l*DW +: DW];
                v      = $signed(lane_v);
                if (v > m) m = v;
            end
            d = m;
            if (sub) begin
                lane_v = cen_word[l*DW +: DW];
                d      = m - $signed(lane_v);
                if (d > hi) d = hi;
                if (d < lo) d = lo;
            end
            r[l*DW +: DW] = d[DW-1:0];
        end
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_out_valid"}, out_valid, 1'b0);
        chk_b({tag, "_c_ready"}, c_ready, 1'b0);
        chk_b({tag, "_nb_ready"}, nb_ready, 1'b0);
        chk_w({tag, "_out_data"}, out_data, '0);
        chk_b({tag, "_out_err"}, out_err, 1'b0);
    endtask

    // Drive one complete group and check its handshakes, latency and result.
    task automatic do_group(input int num, input bit sub, input bit bub, input bit hold);
        int k;
        int idx;
        int cyc;
        bit hs;
        logic [WW-1:0] exp_w;
        logic [WW-1:0] held;
        k = (num > K_MAX) ? K_MAX : num;
        exp_q.push_back(ref_result(k, sub));
        start  = 1'b1;
        num_nb = KW'(num);
        sub_en = sub;
        step();
        start  = 1'b0;
        num_nb = KW'($urandom_range(0, K_MAX));
        sub_en = 1'($urandom_range(0, 1));
        chk_b("busy_after_start", busy, 1'b1);
        if (k == 0) begin
            chk_b("k0_out_valid", out_valid, 1'b1);
            chk_b("k0_c_ready", c_ready, 1'b0);
            chk_b("k0_nb_ready", nb_ready, 1'b0);
        end else if (sub) begin
            nb_valid = 1'b1;
            nb_data  = beats[0];
            c_valid  = 1'b0;
            chk_b("loadc_c_ready", c_ready, 1'b1);
            chk_b("loadc_nb_ready", nb_ready, 1'b0);
            step();
            nb_valid = 1'b0;
            c_valid  = 1'b1;
            c_data   = cen_word;
            step();
            c_valid  = 1'b0;
            c_data   = rand_word(0);
        end
        idx = 0;
        cyc = 0;
        while (idx < k && cyc < 2000) begin
            nb_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
            nb_data  = nb_valid ? beats[idx] : rand_word(0);
            hs       = nb_valid && nb_ready;
            step();
            cyc++;
            if (hs) idx++;
        end
        chk_w("beats_accepted", WW'(idx), WW'(k));
        nb_valid = 1'b1;
        nb_data  = rand_word(0);
        if (k > 0 && sub) begin
            chk_b("sub_latency_gap", out_valid, 1'b0);
            step();
        end
        if (k > 0) chk_b("result_latency", out_valid, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk_b("out_valid_seen", out_valid, 1'b1);
        chk_b("out_nb_ready", nb_ready, 1'b0);
        exp_w = exp_q.pop_front();
        if (hold) begin
            held      = out_data;
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                start  = 1'b1;
                num_nb = KW'($urandom_range(1, K_MAX));
                sub_en = 1'($urandom_range(0, 1));
                step();
                chk_w("hold_data", out_data, held);
                chk_b("hold_valid", out_valid, 1'b1);
                chk_b("hold_nb_ready", nb_ready, 1'b0);
            end
        end
        chk_w("out_data", out_data, exp_w);
        chk_b("out_err", out_err, (k == 0));
        last_out  = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nb_valid  = 1'b0;
        chk_b("idle_after_out", busy, 1'b0);
        chk_b("valid_after_out", out_valid, 1'b0);
        start = 1'b0;
    endtask

    // Directed and random sequence
    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        num_nb    = '0;
        sub_en    = 1'b0;
        c_valid   = 1'b0;
        c_data    = '0;
        nb_valid  = 1'b0;
        nb_data   = '0;
        out_ready = 1'b0;
        cen_word  = '0;
        last_out  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Plain max, K=3, lane0 5,-7,12 -> 12
        beats.delete();
        w = rand_word(0); w[7:0] = 8'd5;  beats.push_back(w);
        w = rand_word(0); w[7:0] = 8'hf9; beats.push_back(w);
        w = rand_word(0); w[7:0] = 8'd12; beats.push_back(w);
        do_group(3, 1'b0, 1'b0, 1'b0);
        chk_w("k3_lane0", WW'(last_out[7:0]), WW'(8'd12));

        // Subtract with saturation at both ends
        cen_word = rand_word(0);
        cen_word[7:0]  = 8'h9c;
        cen_word[15:8] = 8'd10;
        beats.delete();
        w = rand_word(0); w[7:0] = 8'd100; w[15:8] = 8'h80; beats.push_back(w);
        w = rand_word(0); w[7:0] = 8'd90;  w[15:8] = 8'h80; beats.push_back(w);
        do_group(2, 1'b1, 1'b0, 1'b0);
        chk_w("sat_hi_lane0", WW'(last_out[7:0]), WW'(8'h7f));
        chk_w("sat_lo_lane1", WW'(last_out[15:8]), WW'(8'h80));

        // Empty groups in both modes
        beats.delete();
        do_group(0, 1'b0, 1'b0, 1'b0);
        do_group(0, 1'b1, 1'b0, 1'b0);

        // Over-range count clamps to K_MAX beats
        prepare(40, 1'b0);
        do_group(40, 1'b0, 1'b0, 1'b0);

        // Output back-pressure with start pulses in OUT
        prepare(5, 1'b0);
        cen_word = rand_word(0);
        do_group(5, 1'b1, 1'b0, 1'b1);

        // Full-size groups, all-negative lanes, with bubbles
        prepare(32, 1'b1);
        do_group(32, 1'b0, 1'b1, 1'b0);
        prepare(32, 1'b1);
        cen_word = rand_word(0);
        do_group(32, 1'b1, 1'b1, 1'b0);

        // Reset after 2 of 4 beats discards the group
        beats.delete();
        w = '0;
        for (int l = 0; l < LANES; l++) w[l*DW +: DW] = 8'h7f;
        beats.push_back(w);
        beats.push_back(w);
        start  = 1'b1;
        num_nb = KW'(4);
        sub_en = 1'b0;
        step();
        start    = 1'b0;
        nb_valid = 1'b1;
        nb_data  = beats[0];
        step();
        nb_data  = beats[1];
        step();
        nb_valid = 1'b0;
        chk_b("mid_group_busy", busy, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) begin
            step();
            chk_b("no_stale_out", out_valid, 1'b0);
        end
        prepare(4, 1'b1);
        do_group(4, 1'b0, 1'b0, 1'b0);

        // Random groups
        for (int g = 0; g < 8; g++) begin
            int n;
            bit s;
            n = $urandom_range(1, K_MAX);
            s = 1'($urandom_range(0, 1));
            prepare(n, 1'($urandom_range(0, 1)));
            cen_word = rand_word(0);
            do_group(n, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
